// File: rtl/drop_timer.sv
// drop_timer: latches the fall-time limit and runs the elapsed-time counter
// that feeds display_and_drop. Both times are unsigned 8.8 fixed point with an
// LSB of 1/256 s. The prescaler divides clk by TICK_DIV to produce that LSB.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   t_lim_in     limit time from the square-root/height path
//   t_lim_valid  one-cycle strobe qualifying t_lim_in
//   start        one-cycle strobe, begin timing (honoured in ARMED only)
//   abort        level, return to IDLE and clear everything (highest priority)
//   t_act        elapsed time, registered
//   t_lim        latched limit, registered
//   drop_en      registered, high in RUN and FIRED
//   busy         registered, high in RUN
//   done         registered, one-cycle pulse on entry to FIRED
module drop_timer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TICK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] t_lim_in,
   input  logic                  t_lim_valid,
   input  logic                  start,
   input  logic                  abort,
   output logic [DATA_WIDTH-1:0] t_act,
   output logic [DATA_WIDTH-1:0] t_lim,
   output logic                  drop_en,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_FIRED = 2'd3
   } state_t;

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] t_act_q, t_act_d;
   logic [DATA_WIDTH-1:0] t_lim_q, t_lim_d;
   logic [15:0]           presc_q, presc_d;
   logic                  drop_en_q, drop_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d   = state_q;
      t_act_d   = t_act_q;
      t_lim_d   = t_lim_q;
      presc_d   = presc_q;

      if (abort) begin
         state_d = ST_IDLE;
         t_act_d = {DATA_WIDTH{1'b0}};
         t_lim_d = {DATA_WIDTH{1'b0}};
         presc_d = 16'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               t_act_d = {DATA_WIDTH{1'b0}};
               presc_d = 16'd0;
               if (t_lim_valid) begin
                  t_lim_d = t_lim_in;
                  state_d = ST_ARMED;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ARMED: begin
               // A limit arriving with start is the one the run uses.
               if (t_lim_valid) begin
                  t_lim_d = t_lim_in;
               end else begin
                  t_lim_d = t_lim_q;
               end
               if (start) begin
                  t_act_d = {DATA_WIDTH{1'b0}};
                  presc_d = 16'd0;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_RUN: begin
               // Compare on registered values; reaching the limit freezes
               // t_act so it can never pass t_lim or wrap.
               if (t_act_q >= t_lim_q) begin
                  state_d = ST_FIRED;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = 16'd0;
                  t_act_d = t_act_q + DATA_WIDTH'(1);
               end else begin
                  presc_d = presc_q + 16'd1;
               end
            end
            ST_FIRED: begin
               if (t_lim_valid) begin
                  t_lim_d = t_lim_in;
                  t_act_d = {DATA_WIDTH{1'b0}};
                  presc_d = 16'd0;
                  state_d = ST_ARMED;
               end else begin
                  state_d = ST_FIRED;
               end
            end
            default: begin
               state_d = ST_IDLE;
               t_act_d = {DATA_WIDTH{1'b0}};
               t_lim_d = {DATA_WIDTH{1'b0}};
               presc_d = 16'd0;
            end
         endcase
      end

      // Status flags are decoded from the next state so they register
      // alongside the state they describe.
      busy_d    = (state_d == ST_RUN);
      drop_en_d = (state_d == ST_RUN) || (state_d == ST_FIRED);
      done_d    = (state_d == ST_FIRED) && (state_q != ST_FIRED);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         t_act_q   <= {DATA_WIDTH{1'b0}};
         t_lim_q   <= {DATA_WIDTH{1'b0}};
         presc_q   <= 16'd0;
         drop_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         t_act_q   <= t_act_d;
         t_lim_q   <= t_lim_d;
         presc_q   <= presc_d;
         drop_en_q <= drop_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign t_act   = t_act_q;
   assign t_lim   = t_lim_q;
   assign drop_en = drop_en_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_drop_timer.sv
// Bench for drop_timer: directed scenarios plus random operations. The
// reference model tracks the operating mode, the limit and the start edge;
// expected outputs come from the timing formulas (t_act = elapsed/TICK_DIV,
// saturating at the limit). Each start pushes the expected completion into a
// scoreboard that the monitor pops on every done pulse.
module tb_drop_timer;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] t_lim_in = 16'h0;
   logic        t_lim_valid = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] t_act, t_lim;
   logic        drop_en, busy, done;

   drop_timer #(.DATA_WIDTH(16), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .t_lim_in(t_lim_in), .t_lim_valid(t_lim_valid),
      .start(start), .abort(abort), .t_act(t_act), .t_lim(t_lim),
      .drop_en(drop_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Reference model: 0 = idle, 1 = armed, 2 = timing (run or fired)
   int          m_state = 0;
   logic [15:0] m_lim = 16'h0;
   int          m_n = 0;

   typedef struct {
      int          fire_cyc;
      logic [15:0] lim;
   } exp_t;
   exp_t sb_q[$];

   function automatic bit m_fired(input int k);
      return k >= m_n + 1 + int'(m_lim) * TD;
   endfunction

   // Apply one sampled input set to the model; k is the cycle the inputs were driven in.
   function automatic void model_apply(input logic v, input logic [15:0] lim,
                                       input logic s, input logic a, input int k);
      exp_t e;
      if (a) begin
         m_state = 0;
         m_lim   = 16'h0;
         sb_q.delete();
      end else if (m_state == 0) begin
         if (v) begin
            m_state = 1;
            m_lim   = lim;
         end
      end else if (m_state == 1) begin
         if (v) m_lim = lim;
         if (s) begin
            m_state    = 2;
            m_n        = k + 1;
            e.fire_cyc = m_n + 1 + int'(m_lim) * TD;
            e.lim      = m_lim;
            sb_q.push_back(e);
         end
      end else begin
         if (m_fired(k) && v) begin
            m_state = 1;
            m_lim   = lim;
         end
      end
   endfunction

   task automatic step(input logic v, input logic [15:0] lim, input logic s, input logic a);
      @(negedge clk);
      #1;
      t_lim_valid = v;
      t_lim_in    = lim;
      start       = s;
      abort       = a;
      model_apply(v, lim, s, a, cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic wait_fire(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb_q.size() == 0) break;
         step(1'b0, 16'h0, 1'b0, 1'b0);
      end
      check("sb_drained", sb_q.size(), 0);
      sb_q.delete();
   endtask

   // Monitor: compare every cycle against the model, pop the scoreboard on done.
   logic [15:0] e_act, e_lim;
   logic        e_drop, e_busy;
   int          rel, q;
   exp_t        got;
   always @(negedge clk) begin
      e_act = 16'h0; e_lim = 16'h0; e_drop = 1'b0; e_busy = 1'b0;
      rel = 0; q = 0;
      if (m_state == 1) begin
         e_lim = m_lim;
      end else if (m_state == 2) begin
         rel    = cyc - m_n;
         q      = rel / TD;
         e_act  = (q > int'(m_lim)) ? m_lim : 16'(q);
         e_lim  = m_lim;
         e_drop = 1'b1;
         e_busy = (rel <= int'(m_lim) * TD);
      end
      check("t_act", t_act, e_act);
      check("t_lim", t_lim, e_lim);
      check("drop_en", drop_en, e_drop);
      check("busy", busy, e_busy);
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("done_unexpected", done, 1'b0);
         end else begin
            got = sb_q.pop_front();
            check("fire_cycle", cyc, got.fire_cyc);
            check("fire_t_act", t_act, got.lim);
         end
      end else if (sb_q.size() != 0 && sb_q[0].fire_cyc <= cyc) begin
         check("done_missing", done, 1'b1);
         void'(sb_q.pop_front());
      end
   end

   initial begin
      // Reset, then start alone must be ignored
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      step(1'b0, 16'h0, 1'b1, 1'b0);
      idle(3);

      // Nominal run, limit 3
      step(1'b1, 16'd3, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      wait_fire(100);
      idle(2);

      // Zero limit (re-arm from FIRED)
      step(1'b1, 16'd0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      wait_fire(20);
      idle(3);

      // Simultaneous limit and start; strobes during RUN are ignored
      step(1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b1, 16'd5, 1'b0, 1'b0);
      step(1'b1, 16'd2, 1'b1, 1'b0);
      idle(2);
      step(1'b1, 16'd7, 1'b1, 1'b0);
      wait_fire(50);

      // Abort in RUN at t_act = 0x0102, then abort together with start
      step(1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b1, 16'h0200, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      idle(16'h0102 * TD);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      idle(2);
      step(1'b1, 16'd4, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      idle(3);

      // Re-arm from FIRED with 0x0100
      step(1'b1, 16'd1, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      wait_fire(30);
      step(1'b1, 16'h0100, 1'b0, 1'b0);
      idle(2);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      wait_fire(256 * TD + 20);

      // Asynchronous reset mid-RUN at t_act = 5
      step(1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b1, 16'd9, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      idle(5 * TD + 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      m_state = 0;
      m_lim = 16'h0;
      sb_q.delete();
      #1;
      check("rst_t_act", t_act, 16'h0);
      check("rst_t_lim", t_lim, 16'h0);
      check("rst_drop_en", drop_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      idle(2);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step(1'b0, 16'h0, 1'b1, 1'b0);
      idle(3);

      // Random operations
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 7))
            0, 1: step(1'b1, 16'($urandom_range(0, 6)), 1'b0, 1'b0);
            2:    step(1'b0, 16'h0, 1'b1, 1'b0);
            3:    step(1'b1, 16'($urandom_range(0, 6)), 1'b1, 1'b0);
            4:    step(1'b0, 16'h0, 1'b0, 1'b1);
            5:    step(1'b1, 16'($urandom_range(0, 6)), 1'b1, 1'b1);
            6:    idle($urandom_range(1, 6));
            default: wait_fire(200);
         endcase
      end
      wait_fire(200);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
